boot_loader: RTL and testbench

Serial program loader that sits directly upstream of the processor. It receives a framed byte stream, packs the bytes into little-endian 32-bit words, and writes them into the processor's unified word-addressed memory. It holds the processor in reset until a complete, checksum-verified image has been written.

---
 rtl/boot_loader_if.sv | 27 ++
 rtl/boot_loader.sv | 138 +++++++++++++
 tb/tb_boot_loader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// boot_loader_if: byte-stream input and memory-write/status bundle of boot_loader.
//   byte_i/byte_valid_i             : received byte and its one-cycle strobe
//   mem_we_o/mem_addr_o/mem_data_o  : word write port toward processor memory
//   cpu_reset_o/done_o/error_o      : processor reset and load status
// Modport slave is the loader side; master is the stream source / memory side.
interface boot_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            byte_i;
  logic                  byte_valid_i;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_data_o;
  logic                  cpu_reset_o;
  logic                  done_o;
  logic                  error_o;

  modport slave (
    input  byte_i, byte_valid_i,
    output mem_we_o, mem_addr_o, mem_data_o, cpu_reset_o, done_o, error_o
  );

  modport master (
    output byte_i, byte_valid_i,
    input  mem_we_o, mem_addr_o, mem_data_o, cpu_reset_o, done_o, error_o
  );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: receives a framed byte stream (0xA5, 4-byte LE word count,
// data bytes, XOR checksum), packs bytes into little-endian 32-bit words and
// writes them to word-addressed memory. Holds the processor in reset until a
// checksum-verified image has been written.
//   clk      : system clock, posedge
//   reset_i  : synchronous active-high reset
//   bus      : boot_loader_if.slave (byte input, memory write port, status)
module boot_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          reset_i,
  boot_loader_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERROR} state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  // Largest legal word count; one bit wider than the length so 2**32 cannot alias.
  localparam logic [32:0] MAX_LEN   = 33'(1) << ADDR_WIDTH;

  state_t                state_q, state_n;
  logic [1:0]            idx_q, idx_n;
  logic [31:0]           len_q, len_n;
  logic [7:0]            csum_q, csum_n;
  logic [23:0]           word_buf_q, word_buf_n;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_n;
  logic [ADDR_WIDTH:0]   cnt_inc;
  logic [31:0]           len_full;
  logic                  we_q, we_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [31:0]           data_q, data_n;
  logic                  cpu_reset_q, done_q, error_q;

  always_comb begin
    state_n    = state_q;
    idx_n      = idx_q;
    len_n      = len_q;
    csum_n     = csum_q;
    word_buf_n = word_buf_q;
    cnt_n      = cnt_q;
    we_n       = 1'b0;
    addr_n     = addr_q;
    data_n     = data_q;
    cnt_inc    = cnt_q + 1'b1;
    len_full   = {bus.byte_i, len_q[31:8]};

    if (bus.byte_valid_i) begin
      case (state_q)
        IDLE: begin
          if (bus.byte_i == SYNC_BYTE) begin
            csum_n  = 8'h00;
            idx_n   = 2'd0;
            state_n = LEN;
          end
        end
        LEN: begin
          // Length arrives LSB first, so shift in from the top.
          len_n  = len_full;
          csum_n = csum_q ^ bus.byte_i;
          idx_n  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if ({1'b0, len_full} > MAX_LEN) begin
              state_n = ERROR;
            end else if (len_full == 32'd0) begin
              state_n = CSUM;
            end else begin
              state_n = DATA;
              cnt_n   = '0;
            end
          end
        end
        DATA: begin
          csum_n = csum_q ^ bus.byte_i;
          idx_n  = idx_q + 2'd1;
          case (idx_q)
            2'd0:    word_buf_n[7:0]   = bus.byte_i;
            2'd1:    word_buf_n[15:8]  = bus.byte_i;
            2'd2:    word_buf_n[23:16] = bus.byte_i;
            default: begin
              we_n   = 1'b1;
              addr_n = cnt_q[ADDR_WIDTH-1:0];
              data_n = {bus.byte_i, word_buf_q};
              cnt_n  = cnt_inc;
              if (32'(cnt_inc) == len_q) begin
                state_n = CSUM;
              end
            end
          endcase
        end
        CSUM: begin
          state_n = (bus.byte_i == csum_q) ? DONE : ERROR;
        end
        default: ; // DONE and ERROR ignore bytes until reset
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= 32'd0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      cnt_q       <= cnt_n;
      we_q        <= we_n;
      addr_q      <= addr_n;
      data_q      <= data_n;
      // Status is decoded from the next state so it appears with the state change.
      cpu_reset_q <= (state_n != DONE);
      done_q      <= (state_n == DONE);
      error_q     <= (state_n == ERROR);
    end
  end

  // Frame payload registers need no reset: they are reloaded before use.
  always_ff @(posedge clk) begin
    len_q      <= len_n;
    csum_q     <= csum_n;
    word_buf_q <= word_buf_n;
  end

  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_data_o  = data_q;
  assign bus.cpu_reset_o = cpu_reset_q;
  assign bus.done_o      = done_q;
  assign bus.error_o     = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed bench for boot_loader (ADDR_WIDTH = 10).
module tb_boot_loader;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic reset_i;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

  boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write log and pulse-width monitor, sampled mid-cycle.
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            wr_cyc_q[$];
  int            pulse_err = 0;
  logic          we_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_we_o === 1'b1) begin
      wr_addr_q.push_back(bus.mem_addr_o);
      wr_data_q.push_back(bus.mem_data_o);
      wr_cyc_q.push_back(cyc);
      if (we_prev === 1'b1) pulse_err++;
    end
    we_prev = bus.mem_we_o;
  end

  logic [7:0] frame_q[$];

  task automatic do_reset();
    reset_i = 1'b1;
    bus.byte_valid_i = 1'b0;
    bus.byte_i = 8'h00;
    @(posedge clk); #1;
    reset_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.byte_i = b;
    bus.byte_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.byte_valid_i = 1'b0;
    bus.byte_i = 8'h00;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int gap);
    foreach (frame_q[i]) send_byte(frame_q[i], gap);
  endtask

  // Standard two-word frame without its checksum byte.
  task automatic load_std_frame();
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
                8'h13, 8'h00, 8'h00, 8'h00,
                8'h6F, 8'h00, 8'h00, 8'h00};
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.cpu_reset_o !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b expected 1", bus.cpu_reset_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
    checks++; if (bus.error_o !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bus.error_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.mem_we_o); end
    checks++; if (bus.mem_addr_o !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.mem_addr_o); end
    checks++; if (bus.mem_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.mem_data_o); end
  endtask

  task automatic check_two_writes(input string tag, input int base, input int spacing, input int pbase);
    checks++;
    if (wr_addr_q.size() - base !== 2) begin
      errors++; $display("FAIL %s_write_count: got %0d expected 2", tag, wr_addr_q.size() - base);
    end else begin
      checks++; if (wr_addr_q[base] !== 10'd0 || wr_data_q[base] !== 32'h00000013) begin errors++; $display("FAIL %s_word0: got %h@%h expected 00000013@000", tag, wr_data_q[base], wr_addr_q[base]); end
      checks++; if (wr_addr_q[base+1] !== 10'd1 || wr_data_q[base+1] !== 32'h0000006F) begin errors++; $display("FAIL %s_word1: got %h@%h expected 0000006f@001", tag, wr_data_q[base+1], wr_addr_q[base+1]); end
      checks++; if (wr_cyc_q[base+1] - wr_cyc_q[base] !== spacing) begin errors++; $display("FAIL %s_spacing: got %0d expected %0d", tag, wr_cyc_q[base+1] - wr_cyc_q[base], spacing); end
    end
    checks++; if (pulse_err !== pbase) begin errors++; $display("FAIL %s_pulse_width: got %0d long pulses expected 0", tag, pulse_err - pbase); end
  endtask

  task automatic check_done(input string tag);
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL %s_done: got %b expected 1", tag, bus.done_o); end
    checks++; if (bus.cpu_reset_o !== 1'b0) begin errors++; $display("FAIL %s_cpu_reset: got %b expected 0", tag, bus.cpu_reset_o); end
    checks++; if (bus.error_o !== 1'b0) begin errors++; $display("FAIL %s_error: got %b expected 0", tag, bus.error_o); end
  endtask

  task automatic test_valid_frame();
    int base, pbase;
    do_reset();
    base = wr_addr_q.size(); pbase = pulse_err;
    load_std_frame();
    send_frame(0);
    checks++; if (bus.done_o !== 1'b0 || bus.cpu_reset_o !== 1'b1) begin errors++; $display("FAIL valid_pre_csum: got done=%b cpu_reset=%b expected done=0 cpu_reset=1", bus.done_o, bus.cpu_reset_o); end
    send_byte(8'h7E, 0);
    check_done("valid");
    send_byte(8'h00, 2);
    check_two_writes("valid", base, 4, pbase);
  endtask

  task automatic test_junk_sync();
    int base, pbase;
    do_reset();
    base = wr_addr_q.size(); pbase = pulse_err;
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0);
    load_std_frame();
    send_frame(0);
    send_byte(8'h7E, 2);
    check_two_writes("junk", base, 4, pbase);
    check_done("junk");
  endtask

  task automatic test_bad_csum();
    int base, pbase, mid;
    do_reset();
    base = wr_addr_q.size(); pbase = pulse_err;
    load_std_frame();
    send_frame(0);
    send_byte(8'h7F, 0);
    checks++; if (bus.error_o !== 1'b1) begin errors++; $display("FAIL badcsum_error: got %b expected 1", bus.error_o); end
    checks++; if (bus.cpu_reset_o !== 1'b1 || bus.done_o !== 1'b0) begin errors++; $display("FAIL badcsum_status: got cpu_reset=%b done=%b expected 1/0", bus.cpu_reset_o, bus.done_o); end
    check_two_writes("badcsum", base, 4, pbase);
    mid = wr_addr_q.size();
    send_frame(0);
    send_byte(8'h7E, 2);
    checks++; if (wr_addr_q.size() !== mid) begin errors++; $display("FAIL badcsum_later_writes: got %0d expected 0", wr_addr_q.size() - mid); end
    checks++; if (bus.error_o !== 1'b1 || bus.done_o !== 1'b0 || bus.cpu_reset_o !== 1'b1) begin errors++; $display("FAIL badcsum_sticky: got error=%b done=%b cpu_reset=%b expected 1/0/1", bus.error_o, bus.done_o, bus.cpu_reset_o); end
  endtask

  task automatic test_len_zero();
    int base;
    do_reset();
    base = wr_addr_q.size();
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    send_byte(8'h00, 2);
    checks++; if (wr_addr_q.size() !== base) begin errors++; $display("FAIL len0_writes: got %0d expected 0", wr_addr_q.size() - base); end
    check_done("len0");
  endtask

  task automatic test_len_overflow();
    int base;
    do_reset();
    base = wr_addr_q.size();
    frame_q = '{8'hA5, 8'h01, 8'h04, 8'h00, 8'h00};
    send_frame(0);
    checks++; if (bus.error_o !== 1'b1 || bus.cpu_reset_o !== 1'b1 || bus.done_o !== 1'b0) begin errors++; $display("FAIL lenovf_status: got error=%b cpu_reset=%b done=%b expected 1/1/0", bus.error_o, bus.cpu_reset_o, bus.done_o); end
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 2);
    checks++; if (wr_addr_q.size() !== base) begin errors++; $display("FAIL lenovf_writes: got %0d expected 0", wr_addr_q.size() - base); end
  endtask

  // LEN = 2**AW exactly: word i carries the value i; length XOR is 0x04 and
  // every data byte value appears an even number of times, so checksum 0x04.
  task automatic test_len_max();
    int base, pbase, n;
    logic [31:0] w;
    do_reset();
    base = wr_addr_q.size(); pbase = pulse_err;
    frame_q = '{8'hA5, 8'h00, 8'h04, 8'h00, 8'h00};
    for (int i = 0; i < 1024; i++) begin
      w = i;
      frame_q.push_back(w[7:0]); frame_q.push_back(w[15:8]);
      frame_q.push_back(w[23:16]); frame_q.push_back(w[31:24]);
    end
    send_frame(0);
    send_byte(8'h04, 2);
    n = wr_addr_q.size() - base;
    checks++;
    if (n !== 1024) begin
      errors++; $display("FAIL lenmax_count: got %0d expected 1024", n);
    end else begin
      checks++; if (wr_addr_q[base+1023] !== 10'h3FF || wr_data_q[base+1023] !== 32'h000003FF) begin errors++; $display("FAIL lenmax_last: got %h@%h expected 000003ff@3ff", wr_data_q[base+1023], wr_addr_q[base+1023]); end
      checks++; if (wr_addr_q[base+517] !== 10'd517 || wr_data_q[base+517] !== 32'd517) begin errors++; $display("FAIL lenmax_mid: got %h@%h expected 00000205@205", wr_data_q[base+517], wr_addr_q[base+517]); end
    end
    checks++; if (pulse_err !== pbase) begin errors++; $display("FAIL lenmax_pulse_width: got %0d long pulses expected 0", pulse_err - pbase); end
    check_done("lenmax");
  endtask

  task automatic test_reset_mid_frame();
    int base, pbase;
    do_reset();
    base = wr_addr_q.size();
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
                8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00};
    send_frame(0);
    do_reset();
    @(posedge clk); #1;
    checks++; if (wr_addr_q.size() - base !== 1) begin errors++; $display("FAIL midrst_writes: got %0d expected 1", wr_addr_q.size() - base); end
    checks++; if (bus.cpu_reset_o !== 1'b1 || bus.done_o !== 1'b0 || bus.error_o !== 1'b0 || bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL midrst_status: got cpu_reset=%b done=%b error=%b we=%b expected 1/0/0/0", bus.cpu_reset_o, bus.done_o, bus.error_o, bus.mem_we_o); end
    base = wr_addr_q.size(); pbase = pulse_err;
    load_std_frame();
    send_frame(0);
    send_byte(8'h7E, 2);
    check_two_writes("midrst_fresh", base, 4, pbase);
    check_done("midrst_fresh");
  endtask

  task automatic test_gapped();
    int base, pbase;
    do_reset();
    base = wr_addr_q.size(); pbase = pulse_err;
    load_std_frame();
    send_frame(6);
    send_byte(8'h7E, 6);
    check_two_writes("gapped", base, 28, pbase);
    check_done("gapped");
  endtask

  initial begin
    reset_i = 1'b1;
    bus.byte_i = 8'h00;
    bus.byte_valid_i = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_valid_frame();
    test_junk_sync();
    test_bad_csum();
    test_len_zero();
    test_len_overflow();
    test_len_max();
    test_reset_mid_frame();
    test_gapped();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
